// File: rtl/sll32_pipe.sv
// ---------------------------------------------------------------------------
// sll32_pipe -- pipelined 32-bit logical left shifter with carry-out.
//
// An input register captures each accepted operand pair. Five shift stages
// follow it, one per shift-amount bit (shifts of 1, 2, 4, 8 and 16). Each
// stage either shifts its word left, zero-filling from the LSB, or passes it
// through. The unshifted amount bits travel with the data. The carry is the
// last bit pushed past bit 31. Overall that is a[32-b] for b != 0, and 0
// for b == 0.
//
// The whole pipe advances in lock-step whenever the output slot is empty or
// is being consumed. Bubbles travel like data. An accepted operand appears
// on the output five edges after the edge that accepted it.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   a/b presented this cycle
//   in_ready   unit accepts this cycle (combinational from the advance term)
//   a          operand, 32 bits
//   b          shift amount, 0..31
//   out_valid  c/carry valid (registered)
//   out_ready  consumer accepts this cycle
//   c          a << b, zero-filled (registered)
//   carry      last bit shifted out, 0 when b == 0 (registered)
// ---------------------------------------------------------------------------

// Protocol checker: held outputs stay stable and in_ready follows the advance rule.
module sll32_pipe_chk #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] c,
    input logic             carry
);

    // A stalled result must stay put until the consumer takes it.
    property p_hold;
        @(posedge clk) disable iff (rst)
            (out_valid && !out_ready) |=> (out_valid && $stable(c) && $stable(carry));
    endproperty
    a_hold: assert property (p_hold);

    // The input side is ready exactly when the pipe can advance.
    property p_ready;
        @(posedge clk) disable iff (rst)
            in_ready == (!out_valid || out_ready);
    endproperty
    a_ready: assert property (p_ready);

endmodule

module sll32_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [4:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry
);

    // Slot 0 is the input register. Slots 1..STAGES are the shift stages.
    // The last slot drives the outputs directly.
    localparam int NREG = STAGES + 1;

    typedef logic [WIDTH-1:0] word_t;

    word_t           data_r    [NREG];
    logic [4:0]      amt_r     [NREG];
    logic [NREG-1:0] vld_r;
    logic [NREG-1:0] cry_r;

    word_t           data_nx_s [NREG];
    logic [4:0]      amt_nx_s  [NREG];
    logic [NREG-1:0] cry_nx_s;
    logic [NREG-1:0] vld_src_s;
    logic            adv_s;

    // One shift stage. stg selects the shift distance (2^stg) and the amount
    // bit that enables it. The result is {carry, data}. When the stage is
    // disabled, the incoming carry and data pass through unchanged.
    function automatic logic [WIDTH:0] shift_stage(
        input logic [2:0] stg,
        input logic [4:0] amt,
        input word_t      d,
        input logic       cin
    );
        logic [WIDTH:0] r;
        r = {cin, d};
        case (stg)
            3'd0: begin
                if (amt[0]) r = {d[WIDTH-1],  d[WIDTH-2:0],  1'b0};
                else        r = {cin, d};
            end
            3'd1: begin
                if (amt[1]) r = {d[WIDTH-2],  d[WIDTH-3:0],  2'b00};
                else        r = {cin, d};
            end
            3'd2: begin
                if (amt[2]) r = {d[WIDTH-4],  d[WIDTH-5:0],  4'h0};
                else        r = {cin, d};
            end
            3'd3: begin
                if (amt[3]) r = {d[WIDTH-8],  d[WIDTH-9:0],  8'h00};
                else        r = {cin, d};
            end
            3'd4: begin
                if (amt[4]) r = {d[WIDTH-16], d[WIDTH-17:0], 16'h0000};
                else        r = {cin, d};
            end
            default: r = {cin, d};
        endcase
        return r;
    endfunction

    // Global advance: the pipe moves whenever the output slot is free or draining.
    always_comb begin
        adv_s    = ~vld_r[NREG-1] | out_ready;
        in_ready = adv_s;
    end

    // Next-state values for every slot. Each slot is fed from its predecessor.
    // Slot 0 is fed from the input ports.
    always_comb begin
        for (int j = 0; j < NREG; j++) begin
            data_nx_s[3'(j)] = data_r[3'(j)];
            amt_nx_s[3'(j)]  = amt_r[3'(j)];
        end
        cry_nx_s  = cry_r;
        vld_src_s = {vld_r[NREG-2:0], in_valid};

        // The input register starts every operation with a clear carry.
        data_nx_s[3'd0] = a;
        amt_nx_s[3'd0]  = b;
        cry_nx_s[3'd0]  = 1'b0;

        for (int j = 1; j < NREG; j++) begin
            {cry_nx_s[3'(j)], data_nx_s[3'(j)]} = shift_stage(3'(j - 1),
                                                              amt_r[3'(j - 1)],
                                                              data_r[3'(j - 1)],
                                                              cry_r[3'(j - 1)]);
            amt_nx_s[3'(j)] = amt_r[3'(j - 1)];
        end
    end

    // Pipeline registers. Valid bits always shift on advance. Payload is only
    // captured behind a valid bit, so idle cycles never pull unknown operand
    // values into the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {NREG{1'b0}};
            cry_r <= {NREG{1'b0}};
            for (int j = 0; j < NREG; j++) begin
                data_r[3'(j)] <= {WIDTH{1'b0}};
                amt_r[3'(j)]  <= 5'd0;
            end
        end else if (adv_s) begin
            vld_r <= vld_src_s;
            for (int j = 0; j < NREG; j++) begin
                if (vld_src_s[3'(j)]) begin
                    data_r[3'(j)] <= data_nx_s[3'(j)];
                    amt_r[3'(j)]  <= amt_nx_s[3'(j)];
                    cry_r[3'(j)]  <= cry_nx_s[3'(j)];
                end else begin
                    data_r[3'(j)] <= data_r[3'(j)];
                    amt_r[3'(j)]  <= amt_r[3'(j)];
                    cry_r[3'(j)]  <= cry_r[3'(j)];
                end
            end
        end else begin
            vld_r <= vld_r;
            cry_r <= cry_r;
        end
    end

    // The outputs come straight from the last slot's flops.
    always_comb begin
        out_valid = vld_r[NREG-1];
        c         = data_r[NREG-1];
        carry     = cry_r[NREG-1];
    end

    sll32_pipe_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .carry     (carry)
    );

endmodule

// File: doc/sll32_pipe.md
Name: sll32_pipe

Overview:
- Pipelined 32-bit logical left shifter; mirror of the combinational arithmetic right shifter in the ALU IP.
- Five registered stages, one per shift-amount bit (1, 2, 4, 8, 16); zero-fill from LSB.
- Also reports the last bit shifted out (carry).
- Valid/ready handshake on both sides; sits between operand issue and ALU result writeback for multi-cycle shift ops.

Parameters:
- WIDTH, 32, data width. Fixed at 32; shift amount is 5 bits.
- STAGES, 5, pipeline depth. Fixed, one stage per amount bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  a/b presented.
- in_ready  out  1  unit can accept this cycle.
- a  in  32  operand.
- b  in  5  shift amount, 0..31.
- out_valid  out  1  c/carry valid.
- out_ready  in  1  consumer accepts.
- c  out  32  a << b, zero-filled.
- carry  out  1  a[32-b] if b != 0, else 0.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset:
  - All stage valid bits, data, amount and carry registers are cleared to 0.
  - out_valid=0, c=0, carry=0.
  - in_ready=1 in the cycle after rst deasserts.
- Reset mid-operation: all in-flight results are discarded with no output. A transfer offered while rst=1 is ignored.
- Global advance: adv = ~out_valid | out_ready, and in_ready = adv (combinational).
- When adv=1, on each clk edge every stage loads from its predecessor, and stage 1 loads from the input.
  - Stage 1 valid <= in_valid.
  - A bubble (valid=0) propagates like data.
- When adv=0, all stage registers hold.
- Stage k (k=0..4):
  - If amt[k]=1: data <= data_prev << 2^k, low 2^k bits set to 0, and carry <= data_prev[32-2^k].
  - If amt[k]=0: data and carry pass unchanged.
  - The stage-1 carry input is 0.
  - Remaining amount bits travel with the data.
- Carry result: equals the last 1 bit position shifted beyond bit 31 overall, i.e. a[32-b] for b in 1..31.
- Latency and throughput:
  - A transfer accepted at edge N (in_valid & in_ready) appears with out_valid=1 after edge N+5, assuming no stalls.
  - Throughput is 1 result/cycle.
- Ordering is strict FIFO; no reordering, no drops, no duplicates.
- Output stability: while out_valid=1 and out_ready=0, c, carry and out_valid stay stable until accepted.
- Output transfer: when out_valid=1 and out_ready=1 on the same edge as in_valid=1, the output is consumed and new input accepted simultaneously.
- Data is don't-care when the corresponding valid bit is 0. It must not produce an X on c when out_valid=0 after reset (c=0 at reset).
- b=0: c=a, carry=0.
- b=31: c={a[0],31'b0}, carry=a[1].

Test Plan:
- Reset then single op a=32'h0000_0001, b=5'd31, out_ready=1 -> out_valid after 5 cycles; c=32'h8000_0000, carry=0.
- a=32'hF000_000F, b=4 -> c=32'h0000_00F0, carry=1; then b=0 with the same a -> c=32'hF000_000F, carry=0.
- Back-to-back 8 ops, b=0..7, a=32'h8000_0001, out_ready=1 -> 8 consecutive results in order. b=1: c=32'h0000_0002, carry=1. b=7: c=32'h0000_0080, carry=0.
- Backpressure: out_ready=0 for 10 cycles with 5 ops in flight -> in_ready=0 and c held stable. On release, all 5 results emerge in order with no loss.
- Reset asserted with 3 ops in flight -> next cycle out_valid=0 and c=0; no stale result ever appears afterward.
- Random 10k ops with random out_ready against a reference model (a<<b, carry rule) -> zero mismatches.
